// File: rtl/pwm_gen_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_gen_multi
// Description : Multi-channel PWM generator with one shared period counter,
//               programmable prescaler and period, edge- or center-aligned
//               mode, and per-channel debounced increase/decrease buttons.
//               Period, mode and duty updates are double-buffered and only
//               take effect at a period boundary.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               prescale        - counter advances once per prescale+1 clk
//               period          - counter top value (loaded at boundary)
//               center          - 0 edge-aligned, 1 center-aligned
//               step            - duty change per button event
//               inc, dec        - raw per-channel buttons
//               sel             - channel selected for duty readback
//               pwm_out         - registered PWM outputs
//               period_start    - one-clk pulse at each period boundary
//               duty_rd         - shadow duty of channel sel
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_gen_multi #(
    parameter int CH        = 4,
    parameter int RES       = 8,
    parameter int DBW       = 16,
    parameter int DUTY_INIT = 2**(RES-1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            prescale,
    input  logic [RES-1:0]        period,
    input  logic                  center,
    input  logic [RES-1:0]        step,
    input  logic [CH-1:0]         inc,
    input  logic [CH-1:0]         dec,
    input  logic [$clog2(CH)-1:0] sel,
    output logic [CH-1:0]         pwm_out,
    output logic                  period_start,
    output logic [RES:0]          duty_rd
);

    localparam int           SELW        = $clog2(CH);
    localparam logic [RES:0] c_DUTY_INIT = (RES+1)'(DUTY_INIT);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [7:0] r_pre_cnt;
    logic       w_tick;

    assign w_tick = (r_pre_cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Shared period counter
    // ------------------------------------------------------------------
    logic [RES-1:0] r_cnt;
    logic           r_dir_down;
    logic [RES-1:0] r_period_act;
    logic           r_center_act;
    logic           w_boundary;
    logic [RES-1:0] w_pos;
    logic [RES:0]   w_limit;

    // Edge mode ends a period at the top; center mode ends it at the
    // bottom on the way down (the bottom is then held for one more tick
    // as the first count of the next period).
    assign w_boundary = w_tick & (r_center_act ? (r_dir_down && (r_cnt == '0))
                                               : (r_cnt == r_period_act));
    assign period_start = w_boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_dir_down   <= 1'b0;
            r_period_act <= '1;
            r_center_act <= 1'b0;
        end else if (w_boundary) begin
            r_cnt        <= '0;
            r_dir_down   <= 1'b0;
            r_period_act <= period;
            r_center_act <= center;
        end else if (w_tick) begin
            if (!r_center_act) begin
                r_cnt <= r_cnt + RES'(1);
            end else if (!r_dir_down) begin
                // Top is held for one tick while the direction flips.
                if (r_cnt == r_period_act) begin
                    r_dir_down <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + RES'(1);
                end
            end else begin
                r_cnt <= r_cnt - RES'(1);
            end
        end
    end

    // In center mode the compare runs on the distance from the top so the
    // high pulse sits symmetrically around cnt == period_act.
    assign w_pos   = r_center_act ? (r_period_act - r_cnt) : r_cnt;
    assign w_limit = {1'b0, r_period_act} + (RES+1)'(1);

    // ------------------------------------------------------------------
    // Debounce sample enable
    // ------------------------------------------------------------------
    logic [DBW-1:0] r_db_cnt;
    logic           w_se;

    assign w_se = &r_db_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DBW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce, shadow/active duty and output compare
    // ------------------------------------------------------------------
    logic [CH-1:0][RES:0] w_duty_sh;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic           r_inc_s1;
        logic           r_inc_s2;
        logic           r_dec_s1;
        logic           r_dec_s2;
        logic           w_inc_ev;
        logic           w_dec_ev;
        logic [RES:0]   r_duty_sh;
        logic [RES:0]   r_duty_act;
        logic           r_pwm;
        logic [RES+1:0] w_sum;
        logic [RES:0]   w_sh_nxt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_inc_s1 <= 1'b0;
                r_inc_s2 <= 1'b0;
                r_dec_s1 <= 1'b0;
                r_dec_s2 <= 1'b0;
            end else if (w_se) begin
                r_inc_s1 <= inc[g];
                r_inc_s2 <= r_inc_s1;
                r_dec_s1 <= dec[g];
                r_dec_s2 <= r_dec_s1;
            end
        end

        assign w_inc_ev = r_inc_s1 & ~r_inc_s2 & w_se;
        assign w_dec_ev = r_dec_s1 & ~r_dec_s2 & w_se;

        // One extra bit so duty + step cannot overflow before saturation.
        assign w_sum = {1'b0, r_duty_sh} + {2'b00, step};

        always_comb begin
            w_sh_nxt = r_duty_sh;
            if (w_inc_ev && !w_dec_ev) begin
                w_sh_nxt = (w_sum > {1'b0, w_limit}) ? w_limit : w_sum[RES:0];
            end else if (w_dec_ev && !w_inc_ev) begin
                w_sh_nxt = (r_duty_sh >= {1'b0, step}) ? (r_duty_sh - {1'b0, step})
                                                       : '0;
            end
        end

        // Active duty takes the pre-write shadow if both happen in one clk.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_duty_sh  <= c_DUTY_INIT;
                r_duty_act <= c_DUTY_INIT;
                r_pwm      <= 1'b0;
            end else begin
                r_duty_sh <= w_sh_nxt;
                if (w_boundary) begin
                    r_duty_act <= r_duty_sh;
                end
                r_pwm <= ({1'b0, w_pos} < r_duty_act);
            end
        end

        assign w_duty_sh[g] = r_duty_sh;
        assign pwm_out[g]   = r_pwm;
    end

    // ------------------------------------------------------------------
    // Shadow duty readback
    // ------------------------------------------------------------------
    always_comb begin
        duty_rd = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel == SELW'(i)) begin
                duty_rd = w_duty_sh[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Multi-channel, parametrised PWM generator; next generation of the single-channel 10-step PWM block. Drives CH independent PWM outputs from one shared period counter with a programmable prescaler and period, edge- or center-aligned mode, and per-channel debounced increase/decrease buttons. Duty and period updates are double-buffered and take effect only at a period boundary, so outputs never glitch. Sits between the board buttons and pad outputs of the PWM tile.

## Interface
- CH, 4: number of PWM channels (≥2)
- RES, 8: counter/duty resolution in bits
- DBW, 16: debounce sample divider width; buttons are sampled once per 2^DBW clk
- DUTY_INIT, 2^(RES-1): reset value of every duty register
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- prescale  in  8  counter advances once per prescale+1 clk
- period  in  RES  counter top value; edge period = period+1 ticks
- center  in  1  0 = edge-aligned, 1 = center-aligned
- step  in  RES  duty change per button event
- inc  in  CH  raw increase buttons, one per channel
- dec  in  CH  raw decrease buttons, one per channel
- sel  in  clog2(CH)  channel selected for readback
- pwm_out  out  CH  PWM outputs, registered
- period_start  out  1  one-clk pulse at each period boundary
- duty_rd  out  RES+1  shadow duty of channel sel

## Operation
- Prescaler: pre_cnt counts 0..prescale; tick = (pre_cnt == prescale), then wraps to 0. prescale=0 gives tick every clk.
- Period counter cnt (RES bits), advances only on tick, compared against period_act.
  - Edge mode: 0,1,..,period_act,0,...; boundary = tick while cnt == period_act.
  - Center mode: up 0..period_act, then down to 0, then up again. Direction flips at both endpoints, each endpoint held one tick. Boundary = tick while cnt == 0 and direction is down.
  - A center change takes effect at the next boundary; cnt restarts at 0 counting up.
- Boundary actions, same clk: period_start=1, period_act←period, center_act←center, duty_act[i]←duty_sh[i] for all i.
- Debounce: sample enable se every 2^DBW clk. On se, each inc/dec bit shifts into a 2-FF chain (s1,s2). Event = s1 & ~s2 & se, one clk wide.
- Shadow update per channel, computed in RES+1 bits:
  - inc event only: duty_sh = min(duty_sh+step, period_act+1).
  - dec event only: duty_sh = max(duty_sh−step, 0), no wrap.
  - inc and dec in the same clk: no change.
- Output: pwm_out[i] = (cnt < duty_act[i]), registered.
  - duty_act = 0: constant low.
  - duty_act ≥ period_act+1: constant high.
- duty_rd = duty_sh[sel], combinational.

## Timing
- Reset values: pwm_out=0, period_start=0, cnt=0, pre_cnt=0, direction=up, period_act=2^RES−1, center_act=0, duty_sh=duty_act=DUTY_INIT, debounce FFs=0. duty_rd then reads DUTY_INIT.
- Reset asserted mid-period clears all state at once; operation resumes from the reset state on the first clk after deassertion.
- pwm_out changes 1 clk after the cnt update that causes it.
- A button edge is visible on duty_rd within 2 sample periods + 1 clk. It reaches pwm_out only after the next boundary.
- Center-mode output period = 2·(period_act+1) ticks, high time = 2·duty_act ticks, symmetric about cnt=period_act.
- A shadow write and a boundary in the same clk: duty_act takes the pre-write shadow value; the new value applies one period later.
- Runtime change of the period input has no effect until the next boundary. Existing duty_sh values are not re-clamped; duty_sh > period_act+1 gives constant high.

## Test plan
- Reset, prescale=0, period=9, center=0, duty 5 on ch0: after the first boundary, ch0 is high 5 clk and low 5 clk; period_start pulses every 10 clk.
- prescale=3, period=3, duty_sh=2 on ch1: ch1 high 8 clk / low 8 clk; period_start every 16 clk.
- center=1, period=7, duty=3: high 6 ticks centred on cnt=7; period 16 ticks; pulse symmetric about the top.
- step=4, period=9, ch2 at 8: one inc makes duty_rd=10 (saturates) and ch2 is constant high. Then three dec events give 6, 2, 0; ch2 is constant low.
- Bouncing inc pulses shorter than 2^DBW clk give at most one event. inc and dec pressed together on ch3 leave duty_rd unchanged.
- Pulse inc mid-period: duty_rd updates immediately, pwm_out keeps the old duty until period_start. Reset mid-period: all outputs 0 and duty_rd=DUTY_INIT.
